bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter (iterative shift-add-3, "double dabble") for the math game.
//  Converts the ALU result, score or timer value into decimal digits with a start/done handshake.
//  Sits between the datapath and the per-digit 7-seg decoders; each 4-bit output digit drives one decoder.
//  Blanked digits are encoded 4'hF; the 7-seg decoder maps 4'hF to all segments off.
// PARAMETERS
//  WIDTH         8  binary input width
//  DIGITS        3  BCD digits out; elaboration $error unless 10**DIGITS > 2**WIDTH-1
//  SIGNED_IN     0  1: bin_in is two's complement; magnitude converted, sign on negative
//  BLANK_LEADING 1  1: leading zero digits replaced by 4'hF (digit 0 never blanked)
// PORTS
//  clk       in   1         rising-edge clock
//  resetn    in   1         reset; one clock; asynchronous, active-low
//  start     in   1         request; sampled only in IDLE
//  bin_in    in   WIDTH     value; captured on the edge that accepts start
//  busy      out  1         high while state != IDLE
//  done      out  1         one-cycle pulse; digits/negative valid from this cycle
//  digits    out  4*DIGITS  BCD digits; [3:0] = ones digit; held until next done
//  negative  out  1         SIGNED_IN=1 and bin_in < 0; held with digits
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, busy=0, done=0, digits=0, negative=0, shift regs=0.
//  FSM: IDLE -> CONVERT (start=1) -> FORMAT (after WIDTH iterations) -> IDLE.
//   IDLE: on edge E0 with start=1, latch magnitude and sign, clear BCD accumulator, counter=0.
//   CONVERT: edges E1..E(WIDTH); each edge adds 3 to every BCD digit >= 5, then shifts {bcd,bin} left 1.
//    Exit to FORMAT on the edge completing iteration WIDTH.
//   FORMAT: edge E(WIDTH+1) registers digits (blanking applied) and negative, pulses done, returns to IDLE.
//  Latency: done high in the cycle after edge E(WIDTH+1), i.e. WIDTH+1 edges after start is accepted.
//   busy is high for exactly WIDTH+1 cycles.
//  start while busy: ignored; no queueing; in-flight conversion unaffected.
//  start in the done cycle (state IDLE): accepted; back-to-back throughput is one result per WIDTH+1 cycles.
//  bin_in changes after E0: no effect.
//  Signed: magnitude = -bin_in (mod 2**WIDTH), treated as unsigned.
//   Most-negative input: 8'h80 -> magnitude 128, negative=1.
//   negative=0 whenever SIGNED_IN=0.
//  Blanking: scan from the MS digit downward; each zero digit becomes 4'hF until the first nonzero digit.
//   The ones digit is always shown, so value 0 -> {F,F,0}.
//  Reset mid-operation: immediate return to IDLE; no done pulse; outputs take their reset values.
//  digits/negative change only in the done cycle or on reset.
// STRUCTURE
//  Package math_game_pkg holds:
//   - typedef logic [3:0] bcd_t
//   - localparam bcd_t BCD_BLANK = 4'hF
//   - FSM state enum {IDLE, CONVERT, FORMAT}
//  Sub-module bcd_adj3 (combinational, bcd_t in -> bcd_t out, +3 if >= 5) is instantiated DIGITS times via generate.
//  Iteration counter width: $clog2(WIDTH+1).
// TESTING
//  1 Async reset: assert resetn=0 between edges mid-CONVERT -> busy/done/digits/negative 0 with no clock edge; no later done.
//  2 WIDTH=8, bin_in=255, start 1 cycle -> done exactly 9 edges later, digits=12'h255, busy high 9 cycles.
//  3 BLANK_LEADING=1: bin_in=7 -> digits=12'hFF7; bin_in=0 -> 12'hFF0; bin_in=100 -> 12'h100.
//  4 SIGNED_IN=1: bin_in=8'hF6 -> negative=1, digits=12'hF10; 8'h80 -> negative=1, 12'h128; 8'h7F -> negative=0, 12'h127.
//  5 start=1 held at E4 while busy -> single done with first result.
//    start in the done cycle with bin_in=42 -> second done 9 edges later, digits=12'hF42.
//  6 Exhaustive sweep 0..255 (both SIGNED_IN values) vs reference model; done pulse width always exactly 1 cycle.

Source files
------------

// File: rtl/math_game_pkg.sv
// Shared types for the math game display path: BCD digit type, blank code and
// converter FSM states.
package math_game_pkg;

  typedef logic [3:0] bcd_t;

  // The 7-seg decoder turns this code into all segments off.
  localparam bcd_t BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    FORMAT
  } state_e;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more, so the
// following left shift carries into the next decade.
module bcd_adj3
  import math_game_pkg::*;
(
  input  bcd_t d_i,
  output bcd_t d_o
);

  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3) with start/done handshake,
// optional signed input and leading-zero blanking for the 7-seg digits.
module bin_to_bcd_seq
  import math_game_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DIGITS        = 3,
  parameter bit          SIGNED_IN     = 1'b0,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  negative
);

  localparam int unsigned     CntW     = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);
  localparam longint unsigned MaxIn    = (64'd1 << WIDTH) - 64'd1;

  if (pow10(DIGITS) <= MaxIn) begin : g_param_check
    $error("bin_to_bcd_seq: DIGITS too small to represent 2**WIDTH-1");
  end

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]      bin_q, bin_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  sign_q, sign_d;
  logic [4*DIGITS-1:0]   digits_q, digits_d;
  logic                  neg_q, neg_d;
  logic                  done_q, done_d;

  logic [4*DIGITS-1:0]   bcd_adj;
  logic [4*DIGITS-1:0]   fmt;
  logic [WIDTH-1:0]      mag;
  logic                  in_neg;
  logic                  leading;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .d_i(bcd_q[4*g +: 4]),
      .d_o(bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    in_neg = SIGNED_IN ? bin_in[WIDTH-1] : 1'b0;
    mag    = in_neg ? -bin_in : bin_in;
  end

  // Blank zero digits from the top until the first nonzero; ones digit always shown.
  always_comb begin
    fmt     = bcd_q;
    leading = BLANK_LEADING;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (leading && (bcd_q[4*i +: 4] == 4'd0)) begin
        fmt[4*i +: 4] = BCD_BLANK;
      end else begin
        leading = 1'b0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    sign_d   = sign_q;
    digits_d = digits_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = mag;
          sign_d  = in_neg;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + CntW'(1);
        if (cnt_q == LastIter) begin
          state_d = FORMAT;
        end
      end
      FORMAT: begin
        digits_d = fmt;
        neg_d    = sign_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      sign_q   <= 1'b0;
      digits_q <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      sign_q   <= sign_d;
      digits_q <= digits_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign digits   = digits_q;
  assign negative = neg_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: unsigned and signed instances driven in lockstep and
// checked against an arithmetic decimal-digit model.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy_u, done_u, neg_u;
  logic        busy_s, done_s, neg_s;
  logic [11:0] digits_u, digits_s;

  int n_tests;
  int n_fail;

  bin_to_bcd_seq #(
    .WIDTH(8), .DIGITS(3), .SIGNED_IN(1'b0), .BLANK_LEADING(1'b1)
  ) u_dut_u (
    .clk(clk), .resetn(resetn), .start(start), .bin_in(bin_in),
    .busy(busy_u), .done(done_u), .digits(digits_u), .negative(neg_u)
  );

  bin_to_bcd_seq #(
    .WIDTH(8), .DIGITS(3), .SIGNED_IN(1'b1), .BLANK_LEADING(1'b1)
  ) u_dut_s (
    .clk(clk), .resetn(resetn), .start(start), .bin_in(bin_in),
    .busy(busy_s), .done(done_s), .digits(digits_s), .negative(neg_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal digits of mag, leading zeros (above the ones digit) shown as F.
  function automatic logic [11:0] ref_bcd(input int unsigned mag);
    int unsigned d[3];
    logic [11:0] r;
    bit lead;
    d[0] = mag % 10;
    d[1] = (mag / 10) % 10;
    d[2] = (mag / 100) % 10;
    lead = 1'b1;
    r    = '0;
    for (int i = 2; i >= 0; i--) begin
      if (i > 0 && lead && d[i] == 0) begin
        r[4*i +: 4] = 4'hF;
      end else begin
        lead        = 1'b0;
        r[4*i +: 4] = 4'(d[i]);
      end
    end
    return r;
  endfunction

  function automatic int unsigned ref_mag_s(input logic [7:0] v);
    return v[7] ? (256 - int'(v)) : int'(v);
  endfunction

  // Launch one conversion and stop at the negedge where done_u is seen (or timeout).
  // lat counts negedges after the launch negedge; 10 means done followed edge E9.
  task automatic do_conv(input logic [7:0] v, output int lat, output int busy_cyc);
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    bin_in   = 8'($urandom);
    lat      = 1;
    busy_cyc = busy_u ? 1 : 0;
    while (!done_u && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy_u) busy_cyc++;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    #1;
    n_tests++;
    if ({busy_u, done_u, digits_u, neg_u, busy_s, done_s, digits_s, neg_s} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got u=%b/%b/%h/%b s=%b/%b/%h/%b, want all 0",
               busy_u, done_u, digits_u, neg_u, busy_s, done_s, digits_s, neg_s);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_latency;
    int lat, bc;
    do_conv(8'd255, lat, bc);
    n_tests++;
    if (lat !== 10) begin
      n_fail++;
      $display("FAIL latency_255: done after %0d edges, want 9", lat - 1);
    end
    n_tests++;
    if (bc !== 9) begin
      n_fail++;
      $display("FAIL busy_cycles_255: busy %0d cycles, want 9", bc);
    end
    n_tests++;
    if (digits_u !== 12'h255 || neg_u !== 1'b0) begin
      n_fail++;
      $display("FAIL digits_255: got %h neg %b, want 255 neg 0", digits_u, neg_u);
    end
    n_tests++;
    if (done_s !== 1'b1 || digits_s !== 12'hFF1 || neg_s !== 1'b1) begin
      n_fail++;
      $display("FAIL signed_ff: got done %b %h neg %b, want 1 FF1 neg 1",
               done_s, digits_s, neg_s);
    end
    @(negedge clk);
    n_tests++;
    if (done_u !== 1'b0 || done_s !== 1'b0) begin
      n_fail++;
      $display("FAIL done_width_255: done still %b/%b one cycle later, want 0", done_u, done_s);
    end
  endtask

  task automatic test_blanking;
    logic [7:0]  vals[3] = '{8'd7, 8'd0, 8'd100};
    logic [11:0] want[3] = '{12'hFF7, 12'hFF0, 12'h100};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      do_conv(vals[i], lat, bc);
      n_tests++;
      if (lat !== 10 || digits_u !== want[i]) begin
        n_fail++;
        $display("FAIL blank_%0d: got %h (lat %0d), want %h (lat 10)",
                 vals[i], digits_u, lat, want[i]);
      end
    end
  endtask

  task automatic test_signed;
    logic [7:0]  vals[3] = '{8'hF6, 8'h80, 8'h7F};
    logic [11:0] want[3] = '{12'hF10, 12'h128, 12'h127};
    logic        wneg[3] = '{1'b1, 1'b1, 1'b0};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      do_conv(vals[i], lat, bc);
      n_tests++;
      if (done_s !== 1'b1 || digits_s !== want[i] || neg_s !== wneg[i]) begin
        n_fail++;
        $display("FAIL signed_%h: got done %b %h neg %b, want 1 %h neg %b",
                 vals[i], done_s, digits_s, neg_s, want[i], wneg[i]);
      end
      n_tests++;
      if (neg_u !== 1'b0) begin
        n_fail++;
        $display("FAIL unsigned_neg_%h: got negative %b, want 0", vals[i], neg_u);
      end
    end
  endtask

  task automatic test_async_reset;
    int lat, bc, dones;
    do_conv(8'd199, lat, bc);
    @(negedge clk);
    bin_in = 8'd77;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    n_tests++;
    if ({busy_u, done_u, digits_u, neg_u, busy_s, done_s, digits_s, neg_s} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got u=%b/%b/%h/%b s=%b/%b/%h/%b, want all 0",
               busy_u, done_u, digits_u, neg_u, busy_s, done_s, digits_s, neg_s);
    end
    @(negedge clk);
    resetn = 1'b1;
    dones  = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done_u || done_s || busy_u) dones++;
    end
    n_tests++;
    if (dones !== 0 || digits_u !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_no_done: %0d done/busy cycles, digits %h, want 0 and 000",
               dones, digits_u);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc, dones;
    logic [11:0] dig_seen;
    logic        held_ok;
    // start held across E4 and bin_in changed mid-flight
    @(negedge clk);
    bin_in = 8'd200;
    start  = 1'b1;
    dones  = 0;
    dig_seen = '0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == 2) bin_in = 8'd5;
      if (i == 6) start = 1'b0;
      if (done_u) begin
        dones++;
        dig_seen = digits_u;
      end
    end
    n_tests++;
    if (dones !== 1 || dig_seen !== 12'h200) begin
      n_fail++;
      $display("FAIL start_while_busy: %0d dones, digits %h, want 1 and 200", dones, dig_seen);
    end
    // start issued in the done cycle
    do_conv(8'd17, lat, bc);
    bin_in  = 8'd42;
    start   = 1'b1;
    held_ok = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done_u && lat < 40) begin
      if (digits_u !== 12'hF17) held_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    n_tests++;
    if (lat !== 10 || digits_u !== 12'hF42) begin
      n_fail++;
      $display("FAIL back_to_back: got %h after %0d edges, want F42 after 9", digits_u, lat - 1);
    end
    n_tests++;
    if (!held_ok) begin
      n_fail++;
      $display("FAIL digits_held: got digits change during conversion, want F17 held");
    end
  endtask

  task automatic test_sweep;
    int lat, bc;
    int bad_u, bad_s, bad_w;
    logic [11:0] wu, ws;
    bad_u = 0;
    bad_s = 0;
    bad_w = 0;
    for (int v = 0; v < 256; v++) begin
      do_conv(8'(v), lat, bc);
      wu = ref_bcd(v);
      ws = ref_bcd(ref_mag_s(8'(v)));
      if (lat !== 10 || bc !== 9 || digits_u !== wu || neg_u !== 1'b0) begin
        bad_u++;
        if (bad_u < 4)
          $display("FAIL sweep_u_%0d: got %h neg %b lat %0d busy %0d, want %h neg 0 lat 10 busy 9",
                   v, digits_u, neg_u, lat, bc, wu);
      end
      if (done_s !== 1'b1 || digits_s !== ws || neg_s !== v[7]) begin
        bad_s++;
        if (bad_s < 4)
          $display("FAIL sweep_s_%0d: got done %b %h neg %b, want 1 %h neg %b",
                   v, done_s, digits_s, neg_s, ws, v[7]);
      end
      @(negedge clk);
      if (done_u !== 1'b0 || done_s !== 1'b0) begin
        bad_w++;
        if (bad_w < 4)
          $display("FAIL sweep_done_width_%0d: got done %b/%b after pulse, want 0", v, done_u, done_s);
      end
    end
    n_tests++;
    if (bad_u !== 0) begin
      n_fail++;
      $display("FAIL sweep_unsigned: got %0d bad values, want 0", bad_u);
    end
    n_tests++;
    if (bad_s !== 0) begin
      n_fail++;
      $display("FAIL sweep_signed: got %0d bad values, want 0", bad_s);
    end
    n_tests++;
    if (bad_w !== 0) begin
      n_fail++;
      $display("FAIL sweep_done_width: got %0d wide pulses, want 0", bad_w);
    end
  endtask

  task automatic test_random;
    int lat, bc, bad;
    logic [7:0] v;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      v = 8'($urandom);
      do_conv(v, lat, bc);
      if (lat !== 10 || digits_u !== ref_bcd(v) || digits_s !== ref_bcd(ref_mag_s(v))
          || neg_s !== v[7]) begin
        bad++;
        if (bad < 4)
          $display("FAIL random_%h: got %h/%h neg %b lat %0d, want %h/%h neg %b lat 10",
                   v, digits_u, digits_s, neg_s, lat, ref_bcd(v), ref_bcd(ref_mag_s(v)), v[7]);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL random: got %0d bad conversions, want 0", bad);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_latency();
    test_blanking();
    test_signed();
    test_async_reset();
    test_back_to_back();
    test_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
